// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer: FSM states, default NOP,
// instruction size and the word-alignment mask.
package fetch_pkg;

   typedef enum logic [1:0] {
      StBoot = 2'd0,
      StRun  = 2'd1,
      StTrap = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;
   localparam logic [31:0] INST_BYTES       = 32'd4;
   localparam logic [31:0] ALIGN_MASK       = 32'h0000_0003;

   function automatic logic is_misaligned(input logic [31:0] addr);
      return |(addr & ALIGN_MASK);
   endfunction

endpackage

// File: rtl/fetch_if_id_reg.sv
// IF/ID pipeline register with load and clear controls; a cleared or reset
// register always presents NOP_INST so decode never sees a stale word.
module fetch_if_id_reg
   import fetch_pkg::*;
#(
   parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic        clear_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] inst_i,
   output logic        valid_o,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o
);

   logic        valid_q;
   logic [31:0] pc_q;
   logic [31:0] inst_q;

   // Clear wins over load; the PC field is left as-is on clear since it is
   // only meaningful while valid is set.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         pc_q    <= 32'h0;
         inst_q  <= NOP_INST;
      end else if (clear_i) begin
         valid_q <= 1'b0;
         inst_q  <= NOP_INST;
      end else if (load_i) begin
         valid_q <= 1'b1;
         pc_q    <= pc_i;
         inst_q  <= inst_i;
      end
   end

   assign valid_o = valid_q;
   assign pc_o    = pc_q;
   assign inst_o  = inst_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, drives instruction memory, fills IF/ID
// and handles decode stalls, execute redirects and misaligned-target traps.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] NOP_INST     = NOP_INST_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   input  logic        dec_ready,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        misalign_err,
   output logic [31:0] fetch_count
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         misalign_q, misalign_d;
   logic [31:0]  count_q;
   logic         load, clear;
   logic         bad_target;

   assign bad_target = is_misaligned(redirect_target);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      misalign_d = misalign_q;
      load       = 1'b0;
      clear      = 1'b0;
      unique case (state_q)
         StBoot: begin
            state_d = StRun;
            if (redirect_valid) begin
               if (bad_target) begin
                  state_d    = StTrap;
                  misalign_d = 1'b1;
               end else begin
                  pc_d = redirect_target;
               end
            end
         end
         StRun: begin
            if (redirect_valid && bad_target) begin
               state_d    = StTrap;
               misalign_d = 1'b1;
               clear      = 1'b1;
            end else if (redirect_valid) begin
               pc_d  = redirect_target;
               clear = 1'b1;
            end else if (!(if_valid && !dec_ready)) begin
               load = 1'b1;
               pc_d = pc_q + INST_BYTES;
            end
         end
         StTrap: begin
            clear = 1'b1;
         end
         default: begin
            state_d = StBoot;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StBoot;
         pc_q       <= RESET_VECTOR;
         misalign_q <= 1'b0;
         count_q    <= 32'h0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         misalign_q <= misalign_d;
         // Counts every handshake, even on a redirect cycle; decode squashes.
         if (if_valid && dec_ready) begin
            count_q <= count_q + 32'd1;
         end
      end
   end

   fetch_if_id_reg #(
      .NOP_INST (NOP_INST)
   ) u_if_id (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load),
      .clear_i (clear),
      .pc_i    (pc_q),
      .inst_i  (imem_data),
      .valid_o (if_valid),
      .pc_o    (if_pc),
      .inst_o  (if_inst)
   );

   assign imem_addr    = pc_q;
   assign misalign_err = misalign_q;
   assign fetch_count  = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a behavioural model checked every cycle
// plus literal expectations at the key points of each scenario.
module tb_fetch_sequencer;

   localparam logic [31:0] RV  = 32'h0000_0100;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = 32'h0;
   logic        dec_ready = 1'b1;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        misalign_err;
   logic [31:0] fetch_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'd3) ^ 32'hDEAD_0000;
   endfunction

   assign imem_data = mem_word(imem_addr);

   fetch_sequencer #(
      .RESET_VECTOR (RV),
      .NOP_INST     (NOP)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_addr       (imem_addr),
      .imem_data       (imem_data),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .dec_ready       (dec_ready),
      .if_valid        (if_valid),
      .if_pc           (if_pc),
      .if_inst         (if_inst),
      .misalign_err    (misalign_err),
      .fetch_count     (fetch_count)
   );

   // Behavioural model: "booting" = the single post-reset cycle, "trapped" = frozen.
   logic        m_known = 1'b0;
   logic        m_booting, m_trapped;
   logic [31:0] m_pc, m_ifpc, m_inst, m_cnt;
   logic        m_valid, m_err;

   always @(posedge clk) begin
      if (rst) begin
         m_known   <= 1'b1;
         m_booting <= 1'b1;
         m_trapped <= 1'b0;
         m_pc      <= RV;
         m_valid   <= 1'b0;
         m_ifpc    <= 32'h0;
         m_inst    <= NOP;
         m_err     <= 1'b0;
         m_cnt     <= 32'h0;
      end else if (m_known) begin
         if (m_valid && dec_ready) m_cnt <= m_cnt + 1;
         if (m_trapped) begin
            m_valid <= 1'b0;
         end else if (redirect_valid && redirect_target[1:0] != 2'b00) begin
            m_trapped <= 1'b1;
            m_booting <= 1'b0;
            m_err     <= 1'b1;
            m_valid   <= 1'b0;
            m_inst    <= NOP;
         end else if (redirect_valid) begin
            m_booting <= 1'b0;
            m_pc      <= redirect_target;
            m_valid   <= 1'b0;
            m_inst    <= NOP;
         end else if (m_booting) begin
            m_booting <= 1'b0;
         end else if (!(m_valid && !dec_ready)) begin
            m_valid <= 1'b1;
            m_ifpc  <= m_pc;
            m_inst  <= mem_word(m_pc);
            m_pc    <= m_pc + 32'd4;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_known) begin
         check("m_imem_addr", imem_addr, m_pc);
         check("m_if_valid", 32'(if_valid), 32'(m_valid));
         check("m_if_inst", if_inst, m_inst);
         check("m_misalign", 32'(misalign_err), 32'(m_err));
         check("m_count", fetch_count, m_cnt);
         if (m_valid) check("m_if_pc", if_pc, m_ifpc);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic redirect(input logic [31:0] tgt);
      redirect_valid  = 1'b1;
      redirect_target = tgt;
   endtask

   initial begin
      // Reset state
      tick(2);
      check("rst_valid", 32'(if_valid), 32'h0);
      check("rst_if_pc", if_pc, 32'h0);
      check("rst_inst", if_inst, NOP);
      check("rst_addr", imem_addr, RV);
      check("rst_count", fetch_count, 32'h0);
      rst = 1'b0;

      // Boot cycle then straight-line fetch
      tick(1);
      check("boot_valid", 32'(if_valid), 32'h0);
      tick(1);
      check("first_pc", if_pc, 32'h100);
      check("first_inst", if_inst, mem_word(32'h100));
      tick(1);
      check("second_pc", if_pc, 32'h104);

      // Stall for three cycles
      dec_ready = 1'b0;
      tick(3);
      check("stall_pc", if_pc, 32'h104);
      check("stall_addr", imem_addr, 32'h108);
      dec_ready = 1'b1;
      tick(1);
      check("release_pc", if_pc, 32'h108);
      tick(1);
      check("count3", fetch_count, 32'd3);

      // Redirect while stalled
      dec_ready = 1'b0;
      tick(1);
      redirect(32'h200);
      tick(1);
      check("redir_bubble", 32'(if_valid), 32'h0);
      check("redir_addr", imem_addr, 32'h200);
      redirect_valid = 1'b0;
      dec_ready      = 1'b1;
      tick(1);
      check("redir_pc", if_pc, 32'h200);
      tick(1);

      // Redirect on a handshake cycle still counts the handshake
      redirect(32'h400);
      tick(1);
      check("redir_count", fetch_count, 32'd5);

      // PC wrap
      redirect(32'hFFFF_FFFC);
      tick(1);
      redirect_valid = 1'b0;
      tick(1);
      check("wrap_pc0", if_pc, 32'hFFFF_FFFC);
      check("wrap_addr", imem_addr, 32'h0);
      tick(1);
      check("wrap_pc1", if_pc, 32'h0);

      // Misaligned redirect traps; later redirects ignored
      redirect(32'h202);
      tick(1);
      check("trap_err", 32'(misalign_err), 32'h1);
      check("trap_valid", 32'(if_valid), 32'h0);
      check("trap_addr", imem_addr, 32'h4);
      redirect(32'h300);
      tick(1);
      check("trap_ignore", imem_addr, 32'h4);
      redirect_valid = 1'b0;
      tick(2);

      // Reset clears the trap
      rst = 1'b1;
      tick(1);
      check("unrap_err", 32'(misalign_err), 32'h0);
      check("unrap_count", fetch_count, 32'h0);
      rst = 1'b0;
      tick(4);

      // Reset together with a redirect: redirect discarded
      rst = 1'b1;
      redirect(32'h500);
      tick(1);
      check("rstredir_addr", imem_addr, RV);
      check("rstredir_valid", 32'(if_valid), 32'h0);
      rst            = 1'b0;
      redirect_valid = 1'b0;
      tick(2);
      check("rstredir_pc", if_pc, RV);

      // Aligned redirect during the boot cycle
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      redirect(32'h600);
      tick(1);
      redirect_valid = 1'b0;
      check("boot_redir_addr", imem_addr, 32'h600);
      tick(1);
      check("boot_redir_pc", if_pc, 32'h600);
      tick(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
